// File: rtl/riscv_memory_arbiter_if.sv
// Bus bundle between the fetch/load-store units, the arbiter and the memory.
// The arbiter uses the slave view. The master view is the requesters plus the memory.
interface riscv_memory_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_read_en;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport slave (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_read_en, mem_write_en, mem_address, mem_write_data,
      input  mem_read_data
   );

   modport master (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_read_en, mem_write_en, mem_address, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/riscv_memory_arbiter.sv
// Shares one single-port synchronous-read memory between the fetch port and the data port.
// Partial-word stores are done as a read followed by a merged full-word write.
module riscv_memory_arbiter #(
   parameter int ROUND_ROBIN  = 1,
   parameter int MEMORY_WORDS = 1024
) (
   input logic                  clk,
   input logic                  rst,
   riscv_memory_arbiter_if.slave bus
);

   typedef enum logic {ACCEPT, MERGE} state_t;

   state_t      state;
   logic        prefer_data;
   logic        i_resp;
   logic        d_resp;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_be;

   logic        accept;
   logic        conflict;
   logic        grant_d;
   logic        grant_i;
   logic        d_full;
   logic        d_partial;
   logic        in_merge;
   logic [31:0] merged;

   // The depth belongs to the memory instance. It is referenced here only so that it is not flagged as unused.
   logic unused_params;
   assign unused_params = (MEMORY_WORDS > 0);

   // Arbitration. Grants are given only in ACCEPT and never while reset is held.
   always_comb begin
      in_merge  = (state == MERGE) && rst;
      accept    = (state == ACCEPT) && rst;
      conflict  = bus.i_req && bus.d_req;
      d_full    = (bus.d_be == 4'b1111);
      d_partial = (bus.d_be != 4'b1111) && (bus.d_be != 4'b0000);
      grant_d   = accept && bus.d_req &&
                  (!bus.i_req || (ROUND_ROBIN == 0) || prefer_data);
      grant_i   = accept && bus.i_req && !grant_d;
   end

   // Byte merge for the write half of a read-modify-write. Enabled lanes come from the store data.
   always_comb begin
      merged = '0;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = cap_be[b] ? cap_wdata[8*b +: 8] : bus.mem_read_data[8*b +: 8];
      end
   end

   // Memory command. The merge write uses the address captured when the store was granted.
   always_comb begin
      bus.mem_read_en    = grant_i || (grant_d && (!bus.d_we || d_partial));
      bus.mem_write_en   = (grant_d && bus.d_we && d_full) || in_merge;
      bus.mem_address    = in_merge ? cap_addr :
                           grant_d  ? (bus.d_addr & ~32'd3) :
                                      (bus.i_addr & ~32'd3);
      bus.mem_write_data = in_merge ? merged : bus.d_wdata;
   end

   // Requester-facing outputs. Read data passes through from the memory and is qualified by rvalid.
   always_comb begin
      bus.i_gnt    = grant_i;
      bus.d_gnt    = grant_d;
      bus.i_rvalid = i_resp;
      bus.d_rvalid = d_resp;
      bus.i_rdata  = bus.mem_read_data;
      bus.d_rdata  = bus.mem_read_data;
   end

   // Sequencer: state, the round-robin pointer, the response pulses and the captured partial store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ACCEPT;
         prefer_data <= 1'b1;
         i_resp      <= 1'b0;
         d_resp      <= 1'b0;
         cap_addr    <= '0;
         cap_wdata   <= '0;
         cap_be      <= '0;
      end else begin
         i_resp <= grant_i;
         d_resp <= (grant_d && !(bus.d_we && d_partial)) || (state == MERGE);

         if (conflict && grant_d) begin
            prefer_data <= 1'b0;
         end else if (conflict && grant_i) begin
            prefer_data <= 1'b1;
         end

         case (state)
            ACCEPT: begin
               if (grant_d && bus.d_we && d_partial) begin
                  state     <= MERGE;
                  cap_addr  <= bus.d_addr & ~32'd3;
                  cap_wdata <= bus.d_wdata;
                  cap_be    <= bus.d_be;
               end
            end
            MERGE: begin
               state <= ACCEPT;
            end
            default: begin
               state <= ACCEPT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Bench for riscv_memory_arbiter: directed scenarios on a round-robin and a fixed-priority
// instance, then random traffic on the round-robin instance against a transaction-level model.
module tb_riscv_memory_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   riscv_memory_arbiter_if bus_a();
   riscv_memory_arbiter_if bus_b();

   riscv_memory_arbiter #(.ROUND_ROBIN(1), .MEMORY_WORDS(1024)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   riscv_memory_arbiter #(.ROUND_ROBIN(0), .MEMORY_WORDS(1024)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] rd_a;
   logic [31:0] rd_b;
   logic        bd_we;
   logic [9:0]  bd_idx;
   logic [31:0] bd_data;

   // Synchronous-read memory behind instance A, with a backdoor write port for preloading.
   always @(posedge clk) begin
      if (bd_we) begin
         mem_a[bd_idx] <= bd_data;
      end else if (bus_a.mem_write_en) begin
         mem_a[bus_a.mem_address[11:2]] <= bus_a.mem_write_data;
      end
      if (bus_a.mem_read_en) begin
         rd_a <= mem_a[bus_a.mem_address[11:2]];
      end
   end
   assign bus_a.mem_read_data = rd_a;

   // Synchronous-read memory behind instance B.
   always @(posedge clk) begin
      if (bus_b.mem_write_en) begin
         mem_b[bus_b.mem_address[11:2]] <= bus_b.mem_write_data;
      end
      if (bus_b.mem_read_en) begin
         rd_b <= mem_b[bus_b.mem_address[11:2]];
      end
   end
   assign bus_b.mem_read_data = rd_b;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          due;
      bit          is_d;
      bit          has_data;
      logic [31:0] data;
   } resp_t;

   resp_t       rq[$];
   resp_t       r;
   logic [31:0] ref_mem [0:15];
   bit          i_act, d_act, dwe, last_d, merge_cycle;
   bit          eg_i, eg_d, exp_iv, exp_dv, exp_dd;
   logic [31:0] ia, da, dw, merge_word, merge_addr, exp_data, old_word, seed_word;
   logic [3:0]  dbe, wsel;
   logic [1:0]  lsel;
   int          pick;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.i_req = 1'b0; bus_a.i_addr = '0;
      bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_be = 4'b0000;
      bus_a.d_addr = '0; bus_a.d_wdata = '0;
   endtask

   task automatic idle_b();
      bus_b.i_req = 1'b0; bus_b.i_addr = '0;
      bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_be = 4'b0000;
      bus_b.d_addr = '0; bus_b.d_wdata = '0;
   endtask

   task automatic preload_a(input logic [9:0] idx, input logic [31:0] data);
      bd_we = 1'b1; bd_idx = idx; bd_data = data;
      @(posedge clk);
      #1;
      bd_we = 1'b0;
   endtask

   task automatic apply_stimulus_d(input logic we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata);
      bus_a.d_req = 1'b1; bus_a.d_we = we; bus_a.d_be = be;
      bus_a.d_addr = addr; bus_a.d_wdata = wdata;
   endtask

   // Watchdog so the run always ends even if the clocking stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by random traffic.
   initial begin
      rst = 1'b0;
      bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      idle_a();
      idle_b();
      bus_a.i_req = 1'b1; bus_a.d_req = 1'b1;
      bus_b.i_req = 1'b1; bus_b.d_req = 1'b1;

      next_cycle();
      next_cycle();
      #1;
      check_bit("rst_i_gnt", bus_a.i_gnt, 1'b0);
      check_bit("rst_d_gnt", bus_a.d_gnt, 1'b0);
      check_bit("rst_i_rvalid", bus_a.i_rvalid, 1'b0);
      check_bit("rst_d_rvalid", bus_a.d_rvalid, 1'b0);
      check_bit("rst_read_en", bus_a.mem_read_en, 1'b0);
      check_bit("rst_write_en", bus_a.mem_write_en, 1'b0);
      check_bit("rst_b_d_gnt", bus_b.d_gnt, 1'b0);
      idle_a();
      idle_b();
      preload_a(10'd4, 32'h0050_0093);
      preload_a(10'd9, 32'h1122_3344);
      rst = 1'b1;

      $display("[TB] fetch alone");
      next_cycle();
      bus_a.i_req = 1'b1; bus_a.i_addr = 32'h10;
      #1;
      check_bit("f_i_gnt", bus_a.i_gnt, 1'b1);
      check_bit("f_d_gnt", bus_a.d_gnt, 1'b0);
      check_bit("f_read_en", bus_a.mem_read_en, 1'b1);
      check_output("f_addr", bus_a.mem_address, 32'h10);
      next_cycle();
      bus_a.i_req = 1'b0;
      #1;
      check_bit("f_i_rvalid", bus_a.i_rvalid, 1'b1);
      check_output("f_i_rdata", bus_a.i_rdata, 32'h0050_0093);
      check_bit("f_d_rvalid", bus_a.d_rvalid, 1'b0);

      $display("[TB] round-robin conflict");
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         bus_a.i_req = 1'b1; bus_a.i_addr = 32'h24 + 32'(c);
         apply_stimulus_d(1'b0, 4'b0000, 32'h10 + 32'(c), 32'h0);
         #1;
         check_bit("rr_d_gnt", bus_a.d_gnt, (c % 2) == 0);
         check_bit("rr_i_gnt", bus_a.i_gnt, (c % 2) == 1);
         check_output("rr_addr", bus_a.mem_address, ((c % 2) == 0) ? 32'h10 : 32'h24);
         if (c > 0) begin
            check_bit("rr_d_rvalid", bus_a.d_rvalid, ((c - 1) % 2) == 0);
            check_bit("rr_i_rvalid", bus_a.i_rvalid, ((c - 1) % 2) == 1);
            check_output("rr_rdata", bus_a.d_rdata,
                         (((c - 1) % 2) == 0) ? 32'h0050_0093 : 32'h1122_3344);
         end
      end
      next_cycle();
      idle_a();
      #1;
      check_bit("rr_last_i_rvalid", bus_a.i_rvalid, 1'b1);
      check_bit("rr_last_d_rvalid", bus_a.d_rvalid, 1'b0);
      check_output("rr_last_rdata", bus_a.i_rdata, 32'h1122_3344);

      $display("[TB] full store then load");
      next_cycle();
      apply_stimulus_d(1'b1, 4'b1111, 32'h22, 32'hDEAD_BEEF);
      #1;
      check_bit("fs_d_gnt", bus_a.d_gnt, 1'b1);
      check_bit("fs_write_en", bus_a.mem_write_en, 1'b1);
      check_bit("fs_read_en", bus_a.mem_read_en, 1'b0);
      check_output("fs_addr", bus_a.mem_address, 32'h20);
      check_output("fs_wdata", bus_a.mem_write_data, 32'hDEAD_BEEF);
      next_cycle();
      apply_stimulus_d(1'b0, 4'b0000, 32'h20, 32'h0);
      #1;
      check_bit("fs_done", bus_a.d_rvalid, 1'b1);
      check_bit("ld_d_gnt", bus_a.d_gnt, 1'b1);
      check_bit("ld_read_en", bus_a.mem_read_en, 1'b1);
      check_output("ld_addr", bus_a.mem_address, 32'h20);
      next_cycle();
      idle_a();
      #1;
      check_bit("ld_rvalid", bus_a.d_rvalid, 1'b1);
      check_output("ld_rdata", bus_a.d_rdata, 32'hDEAD_BEEF);

      $display("[TB] partial store with fetch waiting");
      next_cycle();
      apply_stimulus_d(1'b1, 4'b0010, 32'h24, 32'h0000_AA00);
      bus_a.i_req = 1'b1; bus_a.i_addr = 32'h10;
      #1;
      check_bit("ps_d_gnt", bus_a.d_gnt, 1'b1);
      check_bit("ps_i_gnt", bus_a.i_gnt, 1'b0);
      check_bit("ps_read_en", bus_a.mem_read_en, 1'b1);
      check_bit("ps_write_en0", bus_a.mem_write_en, 1'b0);
      check_output("ps_addr", bus_a.mem_address, 32'h24);
      next_cycle();
      bus_a.d_req = 1'b0;
      #1;
      check_bit("ps_write_en1", bus_a.mem_write_en, 1'b1);
      check_output("ps_merged", bus_a.mem_write_data, 32'h1122_AA44);
      check_output("ps_merge_addr", bus_a.mem_address, 32'h24);
      check_bit("ps_merge_read_en", bus_a.mem_read_en, 1'b0);
      check_bit("ps_merge_i_gnt", bus_a.i_gnt, 1'b0);
      check_bit("ps_merge_d_rvalid", bus_a.d_rvalid, 1'b0);
      next_cycle();
      #1;
      check_bit("ps_d_rvalid", bus_a.d_rvalid, 1'b1);
      check_bit("ps_after_i_gnt", bus_a.i_gnt, 1'b1);
      check_bit("ps_after_i_rvalid", bus_a.i_rvalid, 1'b0);
      next_cycle();
      idle_a();
      #1;
      check_bit("ps_fetch_rvalid", bus_a.i_rvalid, 1'b1);
      check_output("ps_fetch_rdata", bus_a.i_rdata, 32'h0050_0093);
      check_bit("ps_fetch_d_rvalid", bus_a.d_rvalid, 1'b0);

      $display("[TB] reset during merge");
      preload_a(10'd9, 32'h1122_3344);
      apply_stimulus_d(1'b1, 4'b0010, 32'h24, 32'h0000_AA00);
      #1;
      check_bit("rm_d_gnt", bus_a.d_gnt, 1'b1);
      next_cycle();
      idle_a();
      rst = 1'b0;
      #1;
      check_bit("rm_write_en", bus_a.mem_write_en, 1'b0);
      check_bit("rm_d_rvalid", bus_a.d_rvalid, 1'b0);
      check_bit("rm_i_rvalid", bus_a.i_rvalid, 1'b0);
      next_cycle();
      #1;
      check_bit("rm_d_rvalid2", bus_a.d_rvalid, 1'b0);
      check_bit("rm_write_en2", bus_a.mem_write_en, 1'b0);
      rst = 1'b1;
      next_cycle();
      apply_stimulus_d(1'b0, 4'b0000, 32'h24, 32'h0);
      #1;
      check_bit("rm_ld_gnt", bus_a.d_gnt, 1'b1);
      next_cycle();
      idle_a();
      #1;
      check_bit("rm_ld_rvalid", bus_a.d_rvalid, 1'b1);
      check_output("rm_ld_rdata", bus_a.d_rdata, 32'h1122_3344);

      $display("[TB] fixed priority instance");
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         bus_b.i_req = 1'b1; bus_b.i_addr = 32'h10;
         bus_b.d_req = 1'b1; bus_b.d_we = 1'b0; bus_b.d_addr = 32'h24;
         #1;
         check_bit("fp_d_gnt", bus_b.d_gnt, 1'b1);
         check_bit("fp_i_gnt", bus_b.i_gnt, 1'b0);
         if (c > 0) begin
            check_bit("fp_d_rvalid", bus_b.d_rvalid, 1'b1);
            check_bit("fp_i_rvalid", bus_b.i_rvalid, 1'b0);
         end
      end
      next_cycle();
      bus_b.d_we = 1'b1; bus_b.d_be = 4'b0000; bus_b.d_addr = 32'h30; bus_b.d_wdata = 32'h5A5A_5A5A;
      #1;
      check_bit("z_d_gnt", bus_b.d_gnt, 1'b1);
      check_bit("z_i_gnt", bus_b.i_gnt, 1'b0);
      check_bit("z_read_en", bus_b.mem_read_en, 1'b0);
      check_bit("z_write_en", bus_b.mem_write_en, 1'b0);
      next_cycle();
      bus_b.d_req = 1'b0;
      #1;
      check_bit("z_d_rvalid", bus_b.d_rvalid, 1'b1);
      check_bit("z_then_i_gnt", bus_b.i_gnt, 1'b1);
      next_cycle();
      idle_b();
      #1;
      check_bit("z_i_rvalid", bus_b.i_rvalid, 1'b1);
      check_bit("z_d_rvalid_off", bus_b.d_rvalid, 1'b0);

      $display("[TB] random traffic");
      rst = 1'b0;
      for (int w = 0; w < 16; w++) begin
         seed_word = $urandom;
         ref_mem[w] = seed_word;
         preload_a(10'(w), seed_word);
      end
      rst = 1'b1;
      i_act = 1'b0; d_act = 1'b0; last_d = 1'b0; merge_cycle = 1'b0;
      ia = '0; da = '0; dw = '0; dwe = 1'b0; dbe = '0;
      for (int n = 0; n < 410; n++) begin
         next_cycle();
         if (!i_act && n < 400 && $urandom_range(0, 2) != 0) begin
            i_act = 1'b1;
            wsel = 4'($urandom_range(0, 15)); lsel = 2'($urandom_range(0, 3));
            ia = {26'd0, wsel, lsel};
         end
         if (!d_act && n < 400 && $urandom_range(0, 2) != 0) begin
            d_act = 1'b1;
            wsel = 4'($urandom_range(0, 15)); lsel = 2'($urandom_range(0, 3));
            da = {26'd0, wsel, lsel};
            dw = $urandom;
            dwe = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            dbe = (pick == 0) ? 4'b1111 : (pick == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
         end
         bus_a.i_req = i_act; bus_a.i_addr = ia;
         bus_a.d_req = d_act; bus_a.d_we = dwe; bus_a.d_be = dbe;
         bus_a.d_addr = da; bus_a.d_wdata = dw;
         #1;

         eg_i = 1'b0; eg_d = 1'b0;
         if (!merge_cycle) begin
            if (i_act && d_act) begin
               eg_d = !last_d;
               eg_i = last_d;
               last_d = eg_d;
            end else begin
               eg_d = d_act;
               eg_i = i_act;
            end
         end
         check_bit("rnd_i_gnt", bus_a.i_gnt, eg_i);
         check_bit("rnd_d_gnt", bus_a.d_gnt, eg_d);

         exp_iv = 1'b0; exp_dv = 1'b0; exp_dd = 1'b0; exp_data = '0;
         if (rq.size() > 0 && rq[0].due == n) begin
            r = rq.pop_front();
            exp_iv = !r.is_d;
            exp_dv = r.is_d;
            exp_dd = r.is_d && r.has_data;
            exp_data = r.data;
         end
         check_bit("rnd_i_rvalid", bus_a.i_rvalid, exp_iv);
         check_bit("rnd_d_rvalid", bus_a.d_rvalid, exp_dv);
         if (exp_iv) check_output("rnd_i_rdata", bus_a.i_rdata, exp_data);
         if (exp_dd) check_output("rnd_d_rdata", bus_a.d_rdata, exp_data);

         if (merge_cycle) begin
            check_bit("rnd_m_write_en", bus_a.mem_write_en, 1'b1);
            check_bit("rnd_m_read_en", bus_a.mem_read_en, 1'b0);
            check_output("rnd_m_addr", bus_a.mem_address, merge_addr);
            check_output("rnd_m_wdata", bus_a.mem_write_data, merge_word);
            merge_cycle = 1'b0;
         end else if (eg_i) begin
            check_bit("rnd_f_read_en", bus_a.mem_read_en, 1'b1);
            check_bit("rnd_f_write_en", bus_a.mem_write_en, 1'b0);
            check_output("rnd_f_addr", bus_a.mem_address, ia & ~32'd3);
            rq.push_back('{due: n + 1, is_d: 1'b0, has_data: 1'b1, data: ref_mem[ia[5:2]]});
            i_act = 1'b0;
         end else if (eg_d) begin
            if (!dwe) begin
               check_bit("rnd_l_read_en", bus_a.mem_read_en, 1'b1);
               check_bit("rnd_l_write_en", bus_a.mem_write_en, 1'b0);
               check_output("rnd_l_addr", bus_a.mem_address, da & ~32'd3);
               rq.push_back('{due: n + 1, is_d: 1'b1, has_data: 1'b1, data: ref_mem[da[5:2]]});
            end else if (dbe == 4'b1111) begin
               check_bit("rnd_s_write_en", bus_a.mem_write_en, 1'b1);
               check_bit("rnd_s_read_en", bus_a.mem_read_en, 1'b0);
               check_output("rnd_s_addr", bus_a.mem_address, da & ~32'd3);
               check_output("rnd_s_wdata", bus_a.mem_write_data, dw);
               ref_mem[da[5:2]] = dw;
               rq.push_back('{due: n + 1, is_d: 1'b1, has_data: 1'b0, data: 32'h0});
            end else if (dbe == 4'b0000) begin
               check_bit("rnd_z_read_en", bus_a.mem_read_en, 1'b0);
               check_bit("rnd_z_write_en", bus_a.mem_write_en, 1'b0);
               rq.push_back('{due: n + 1, is_d: 1'b1, has_data: 1'b0, data: 32'h0});
            end else begin
               check_bit("rnd_p_read_en", bus_a.mem_read_en, 1'b1);
               check_bit("rnd_p_write_en", bus_a.mem_write_en, 1'b0);
               check_output("rnd_p_addr", bus_a.mem_address, da & ~32'd3);
               old_word = ref_mem[da[5:2]];
               for (int b = 0; b < 4; b++) begin
                  merge_word[8*b +: 8] = dbe[b] ? dw[8*b +: 8] : old_word[8*b +: 8];
               end
               ref_mem[da[5:2]] = merge_word;
               merge_addr = da & ~32'd3;
               merge_cycle = 1'b1;
               rq.push_back('{due: n + 2, is_d: 1'b1, has_data: 1'b0, data: 32'h0});
            end
            d_act = 1'b0;
         end else begin
            check_bit("rnd_idle_read_en", bus_a.mem_read_en, 1'b0);
            check_bit("rnd_idle_write_en", bus_a.mem_write_en, 1'b0);
         end
      end
      checks++;
      assert (rq.size() == 0) else begin
         failures++;
         $error("[TB] FAIL rnd_drain observed=%0d expected=0", rq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
